// File: rtl/rv32i_apb_master.sv
// RV32I data-port to APB3 bridge: one SETUP/ACCESS transfer per core request in the 0x1xxx_xxxx window.
// Optional build macro APB_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT cycles.
module rv32i_apb_master #(
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           addr,
  input  logic [31:0]           w_data,
  input  logic [3:0]            byte_enable,
  output logic                  ready,
  output logic [31:0]           r_data,
  output logic                  bus_err,
  output logic [31:0]           PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 4) begin : g_bad_num_slaves
    $error("rv32i_apb_master: NUM_SLAVES must be in 1..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
    $error("rv32i_apb_master: TIMEOUT must be in 1..31");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam logic [2:0] NsLim = 3'(NUM_SLAVES);

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        pwrite_q, pwrite_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeoutHit;

  logic req, inWin, idxOk;
  assign req   = MemRead | MemWrite;
  assign inWin = (addr[31:28] == 4'h1);
  assign idxOk = ({1'b0, addr[13:12]} < NsLim);

`ifdef APB_TIMEOUT_EN
  localparam logic [4:0] TmoLast = 5'(TIMEOUT - 1);
  logic [4:0] tmo_q, tmo_d;

  // Counts stalled ACCESS cycles; a same-cycle PREADY always takes priority over expiry.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == SETUP) tmo_d = 5'd0;
    else if (state_q == ACCESS && !PREADY) tmo_d = tmo_q + 5'd1;
  end

  assign timeoutHit = (state_q == ACCESS) && !PREADY && (tmo_q == TmoLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= 5'd0;
    else      tmo_q <= tmo_d;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pwrite_q <= pwrite_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // An in-window request to a missing slave never reaches the bus; it only raises bus_err.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pwrite_d = pwrite_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && inWin) begin
          if (idxOk) begin
            state_d  = SETUP;
            paddr_d  = addr;
            pwdata_d = w_data;
            pwrite_d = MemWrite;
            pstrb_d  = MemWrite ? byte_enable : 4'b0000;
            idx_d    = addr[13:12];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_d = IDLE;
          err_d   = PSLVERR;
          if (!pwrite_q) rdata_d = PRDATA;
        end else if (timeoutHit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_q == IDLE);
    PENABLE = (state_q == ACCESS);
    PSEL    = '0;
    if (state_q != IDLE) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (idx_q == 2'(i)) PSEL[i] = 1'b1;
      end
    end
  end

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
  assign PWRITE  = pwrite_q;
  assign r_data  = rdata_q;
  assign bus_err = err_q;

endmodule
